// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read memory between the instruction-fetch (I) and load/store (D) ports; D wins ties unless MEM_ARB_RR_EN is defined.
// Latency: the request is sampled in IDLE, the access happens in XFER, and the ack pulses in DONE, so one access completes every 3 cycles.
// Backpressure: requesters hold req and payload until their ack; req inputs are ignored outside IDLE.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rd,
   output logic          busy,
   output logic          grant_d
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

`ifdef MEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   logic [1:0]    state;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          lat_we;
   logic          last_winner;   // 1 = D was served last
   logic          d_win;

   // On a tie, round-robin hands the slot to whichever port was not served last.
   assign d_win = d_req & (~i_req | ~RR_EN | ~last_winner);

   assign mem_addr = lat_addr;
   assign mem_wd   = lat_wdata;
   assign mem_we   = (state == XFER) & lat_we;
   assign busy     = (state != IDLE);
   assign i_ack    = (state == DONE) & ~grant_d;
   assign d_ack    = (state == DONE) & grant_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         lat_we      <= 1'b0;
         grant_d     <= 1'b0;
         last_winner <= 1'b0;
         rd_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  grant_d  <= d_win;
                  lat_addr <= d_win ? d_addr : i_addr;
                  lat_we   <= d_win & d_we;
                  if (d_win) lat_wdata <= d_wdata;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (!lat_we) rd_data <= mem_rd;
               state <= DONE;
            end
            DONE: begin
               last_winner <= grant_d;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
